mealy_seq_ctrl: RTL

- Serialising controller and scheduler wrapped around a programmable Mealy sequence-detector core.
- Accepts parallel words on a valid/ready handshake and shifts them MSB-first, one bit per clock, into the detector.
- Holds the programmable target pattern and counts matches.
- Sits between a byte-wide producer and the serial detection path; replaces hand-driven x/clk stimulus of the detector.

---
 rtl/mealy_seq_pkg.sv | 14 +
 rtl/mealy_seq_ctrl_if.sv | 32 +++
 rtl/mealy_det_core.sv | 40 ++++
 rtl/mealy_seq_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/mealy_seq_pkg.sv
// Shared types and default sizing for the serial sequence-detector controller.
// Both the controller and the detector core import this package.
package mealy_seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/mealy_seq_ctrl_if.sv
// Producer-side word handshake and pattern configuration bus of mealy_seq_ctrl.
// The producer drives the master modport; the controller uses the slave modport.
interface mealy_seq_ctrl_if
    import mealy_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W
) ();

    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (
        output cfg_we,
        output cfg_pattern,
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  cfg_we,
        input  cfg_pattern,
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/mealy_det_core.sv
// Programmable overlapping Mealy sequence detector: keeps the last PAT_W-1 bits
// and a saturating count of how many of them are real, and compares them with the pattern.
module mealy_det_core
    import mealy_seq_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    output logic             hit
);

    localparam int VC_W = $clog2(PAT_W);
    localparam logic [VC_W-1:0] VC_FULL = VC_W'(PAT_W - 1);

    logic [PAT_W-2:0] history;
    logic [VC_W-1:0]  valid_count;
    logic [PAT_W-1:0] window;

    // The oldest history bit lines up with the pattern MSB.
    assign window = {history, x};
    assign hit    = en && (valid_count == VC_FULL) && (window == pattern);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            history     <= '0;
            valid_count <= '0;
        end else if (en) begin
            history <= window[PAT_W-2:0];
            if (valid_count != VC_FULL) begin
                valid_count <= valid_count + VC_W'(1);
            end
        end
    end

endmodule

// File: rtl/mealy_seq_ctrl.sv
// Word-to-serial controller around mealy_det_core: accepts words, shifts them MSB-first
// into the detector and counts hits. Optional sticky interrupt via MEALY_SEQ_IRQ_EN.
module mealy_seq_ctrl
    import mealy_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    mealy_seq_ctrl_if.slave  bus,
    output logic             busy,
    output logic             x_mon,
    output logic             hit,
    output logic [CNT_W-1:0] hit_count
`ifdef MEALY_SEQ_IRQ_EN
    ,
    input  logic             irq_clr,
    output logic             irq
`endif
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PAT_W-1:0]  pattern_q;
    logic              ready;
    logic              cfg_load;
    logic              shift_en;

    assign bus.in_ready = ready;

    // Everything is gated by rst so outputs read as idle while reset is held.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        ready    = 1'b0;
        busy     = 1'b0;
        x_mon    = 1'b0;
        cfg_load = 1'b0;
        shift_en = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    ready    = !bus.cfg_we;
                    cfg_load = bus.cfg_we;
                    if (bus.in_valid && !bus.cfg_we) begin
                        shreg_d = bus.in_data;
                        idx_d   = IDX_LAST;
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    busy     = 1'b1;
                    shift_en = 1'b1;
                    x_mon    = shreg_q[idx_q];
                    if (idx_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_q <= '0;
        end else if (cfg_load) begin
            pattern_q <= bus.cfg_pattern;
        end
    end

    // A pattern write restarts the statistics along with the detector history.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count <= '0;
        end else if (cfg_load) begin
            hit_count <= '0;
        end else if (hit && (hit_count != COUNT_MAX)) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

    mealy_det_core #(
        .PAT_W(PAT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .en      (shift_en),
        .clr     (cfg_load),
        .x       (x_mon),
        .pattern (pattern_q),
        .hit     (hit)
    );

`ifdef MEALY_SEQ_IRQ_EN
    // Set has priority so a hit coinciding with a clear is never lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            irq <= 1'b0;
        end else if (hit) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

endmodule
